// File: rtl/frame_dbuf_ram.sv
// Double-buffered frame store for a scanned LED panel.
// The scan driver reads one word per section per cycle from the front buffer,
// while pixel writes and clears go to the back buffer. Buffers swap on frame_done.
module frame_dbuf_ram #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned PANEL_WIDTH    = 64,
  parameter int unsigned PANEL_HEIGHT   = 32,
  parameter int unsigned SCAN_SECTIONS  = 2,
  parameter logic [BITS_PER_PIXEL-1:0] CLEAR_VALUE = '0,
  localparam int unsigned FRAME_WORDS   = PANEL_WIDTH * PANEL_HEIGHT,
  localparam int unsigned SECTION_WORDS = FRAME_WORDS / SCAN_SECTIONS,
  localparam int unsigned WA            = $clog2(FRAME_WORDS),
  localparam int unsigned RA            = $clog2(SECTION_WORDS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WA-1:0]                       write_addr,
  input  logic [BITS_PER_PIXEL-1:0]           write_data,
  input  logic                                write_en,
  input  logic [RA-1:0]                       read_addr,
  input  logic                                read_en,
  output logic [SCAN_SECTIONS*BITS_PER_PIXEL-1:0] read_data,
  output logic                                read_valid,
  input  logic                                frame_done,
  input  logic                                swap_req,
  output logic                                swap_pending,
  output logic                                swap_ack,
  input  logic                                clear_req,
  output logic                                busy,
  output logic                                front_sel
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              front_nx;
  logic              ack_nx;
  logic              swap_latch, latch_nx;
  logic [WA-1:0]     clr_cnt, clr_cnt_nx;

  // Single back-buffer write port shared by pixel writes and the clear sweep
  logic                      wr_go_c;
  logic [WA-1:0]             wr_addr_c;
  logic [BITS_PER_PIXEL-1:0] wr_data_c;

  logic [BITS_PER_PIXEL-1:0] rd_word [SCAN_SECTIONS];

  // Control state and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_ack     <= 1'b0;
      swap_latch   <= 1'b0;
      swap_pending <= 1'b0;
      busy         <= 1'b0;
      clr_cnt      <= '0;
    end else begin
      state        <= state_nx;
      front_sel    <= front_nx;
      swap_ack     <= ack_nx;
      swap_latch   <= latch_nx;
      swap_pending <= (state_nx == SWAP_WAIT) || latch_nx;
      busy         <= (state_nx == CLEAR);
      clr_cnt      <= clr_cnt_nx;
    end
  end

  // Next-state logic: clear has priority, swaps only ever happen on frame_done
  always_comb begin
    state_nx   = state;
    front_nx   = front_sel;
    ack_nx     = 1'b0;
    latch_nx   = swap_latch;
    clr_cnt_nx = clr_cnt;
    wr_go_c    = 1'b0;
    wr_addr_c  = write_addr;
    wr_data_c  = write_data;
    unique case (state)
      IDLE: begin
        wr_go_c = write_en;
        if (clear_req) begin
          state_nx   = CLEAR;
          clr_cnt_nx = '0;
          latch_nx   = swap_req;
        end else if (swap_req) begin
          if (frame_done) begin
            front_nx = ~front_sel;
            ack_nx   = 1'b1;
          end else begin
            state_nx = SWAP_WAIT;
          end
        end
      end
      CLEAR: begin
        wr_go_c   = 1'b1;
        wr_addr_c = clr_cnt;
        wr_data_c = CLEAR_VALUE;
        if (swap_req) latch_nx = 1'b1;
        if (clr_cnt == WA'(FRAME_WORDS - 1)) begin
          clr_cnt_nx = '0;
          latch_nx   = 1'b0;
          state_nx   = (swap_latch || swap_req) ? SWAP_WAIT : IDLE;
        end else begin
          clr_cnt_nx = clr_cnt + WA'(1);
        end
      end
      SWAP_WAIT: begin
        wr_go_c = write_en;
        if (frame_done) begin
          front_nx = ~front_sel;
          ack_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // One bank per section, each holding that section of both buffers
  for (genvar s = 0; s < SCAN_SECTIONS; s++) begin : g_bank
    logic [BITS_PER_PIXEL-1:0] mem [2*SECTION_WORDS];
    logic                      bank_we_c;

    assign bank_we_c = wr_go_c && ((wr_addr_c >> RA) == WA'(s));

    // Back-buffer write, addressed by {buffer, offset}
    always_ff @(posedge clk) begin
      if (bank_we_c) mem[{~front_sel, wr_addr_c[RA-1:0]}] <= wr_data_c;
    end

    assign rd_word[s] = mem[{front_sel, read_addr}];
  end

  // Registered front-buffer read, held while read_en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_en;
      if (read_en) begin
        for (int s = 0; s < SCAN_SECTIONS; s++) begin
          read_data[s*BITS_PER_PIXEL +: BITS_PER_PIXEL] <= rd_word[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_dbuf_ram.sv
// Bench for frame_dbuf_ram: a 2-section and a 4-section instance share one
// stimulus stream and are checked against a frame-level model every cycle.
module tb_frame_dbuf_ram;

  localparam int unsigned FW = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] write_addr;
  logic [23:0] write_data;
  logic        write_en;
  logic [9:0]  read_addr;
  logic        read_en;
  logic        frame_done;
  logic        swap_req;
  logic        clear_req;

  logic [47:0] rd2;
  logic        rv2, sp2, sa2, bz2, fs2;
  logic [95:0] rd4;
  logic        rv4, sp4, sa4, bz4, fs4;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  frame_dbuf_ram u_dut2 (
    .clk(clk), .rst_n(rst_n), .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .read_addr(read_addr), .read_en(read_en),
    .read_data(rd2), .read_valid(rv2), .frame_done(frame_done), .swap_req(swap_req),
    .swap_pending(sp2), .swap_ack(sa2), .clear_req(clear_req), .busy(bz2),
    .front_sel(fs2)
  );

  frame_dbuf_ram #(.SCAN_SECTIONS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .read_addr(read_addr[8:0]), .read_en(read_en),
    .read_data(rd4), .read_valid(rv4), .frame_done(frame_done), .swap_req(swap_req),
    .swap_pending(sp4), .swap_ack(sa4), .clear_req(clear_req), .busy(bz4),
    .front_sel(fs4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: two pixel arrays, which one is shown, clear progress, swap latch
  logic [23:0] frame [2][FW];
  bit          known [2][FW];
  int          m_front = 0, m_pend = 0, m_left = 0, m_ack = 0, m_valid = 0;
  logic [47:0] m_rd2 = '0;
  logic [95:0] m_rd4 = '0;
  bit          m_k2 = 1'b1, m_k4 = 1'b1;
  int          m_back, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_front = 0; m_pend = 0; m_left = 0; m_ack = 0; m_valid = 0;
      m_rd2 = '0; m_rd4 = '0; m_k2 = 1'b1; m_k4 = 1'b1;
    end else begin
      m_back = 1 - m_front;
      m_valid = read_en ? 1 : 0;
      if (read_en) begin
        m_k2 = 1'b1;
        m_k4 = 1'b1;
        for (int s = 0; s < 2; s++) begin
          m_idx = s * 1024 + int'(read_addr);
          m_rd2[s*24 +: 24] = frame[m_front][m_idx];
          m_k2 = m_k2 & known[m_front][m_idx];
        end
        for (int s = 0; s < 4; s++) begin
          m_idx = s * 512 + int'(read_addr[8:0]);
          m_rd4[s*24 +: 24] = frame[m_front][m_idx];
          m_k4 = m_k4 & known[m_front][m_idx];
        end
      end
      m_ack = 0;
      if (m_left > 0) begin
        m_idx = FW - m_left;
        frame[m_back][m_idx] = 24'h0;
        known[m_back][m_idx] = 1'b1;
        m_left--;
        if (swap_req) m_pend = 1;
      end else begin
        if (write_en) begin
          frame[m_back][write_addr] = write_data;
          known[m_back][write_addr] = 1'b1;
        end
        if (m_pend != 0) begin
          if (frame_done) begin m_front = m_back; m_ack = 1; m_pend = 0; end
        end else if (clear_req) begin
          m_left = FW;
          m_pend = swap_req ? 1 : 0;
        end else if (swap_req) begin
          if (frame_done) begin m_front = m_back; m_ack = 1; end
          else m_pend = 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("front_sel2", 96'(fs2), 96'(m_front));
      chk("front_sel4", 96'(fs4), 96'(m_front));
      chk("swap_pending2", 96'(sp2), 96'(m_pend));
      chk("swap_pending4", 96'(sp4), 96'(m_pend));
      chk("swap_ack2", 96'(sa2), 96'(m_ack));
      chk("swap_ack4", 96'(sa4), 96'(m_ack));
      chk("busy2", 96'(bz2), 96'(m_left > 0));
      chk("busy4", 96'(bz4), 96'(m_left > 0));
      chk("read_valid2", 96'(rv2), 96'(m_valid));
      chk("read_valid4", 96'(rv4), 96'(m_valid));
      if (m_k2) chk("read_data2", 96'(rd2), 96'(m_rd2));
      if (m_k4) chk("read_data4", rd4, m_rd4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [9:0] a);
    read_addr = a;
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  task automatic do_swap_now();
    swap_req = 1'b1;
    frame_done = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_done = 1'b0;
  endtask

  // Counts busy cycles after clear_req; optional stray writes and a frame_done pulse
  task automatic run_clear(input string name, input bit with_swap, input bit junk_writes);
    int cnt;
    clear_req = 1'b1;
    swap_req = with_swap;
    tick();
    clear_req = 1'b0;
    swap_req = 1'b0;
    cnt = 0;
    while (bz2 && cnt < 3000) begin
      cnt++;
      write_en = junk_writes;
      write_addr = 11'(cnt);
      write_data = 24'hABCDEF;
      frame_done = (cnt == 500);
      tick();
    end
    write_en = 1'b0;
    frame_done = 1'b0;
    chk(name, 96'(cnt), 96'd2048);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    write_addr = '0; write_data = '0; write_en = 1'b0;
    read_addr = '0; read_en = 1'b0;
    frame_done = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    #1;
    chk("rst_front_sel", 96'(fs2), 96'd0);
    chk("rst_busy", 96'(bz2), 96'd0);
    chk("rst_read_data", rd4, 96'd0);
    chk("rst_read_valid", 96'(rv2), 96'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Fill back buffer with data = address, then swap on the same frame_done
    for (int a = 0; a < int'(FW); a++) begin
      write_en = 1'b1;
      write_addr = 11'(a);
      write_data = 24'(a);
      tick();
    end
    write_en = 1'b0;
    do_swap_now();
    chk("imm_swap_front", 96'(fs2), 96'd1);
    chk("imm_swap_ack", 96'(sa2), 96'd1);
    tick();
    chk("imm_swap_ack_drop", 96'(sa2), 96'd0);

    do_read(10'd5);
    chk("read5_2sec", 96'(rd2), 96'h000405_000005);
    chk("read5_4sec", rd4, {24'h000605, 24'h000405, 24'h000205, 24'h000005});
    tick();
    chk("hold_valid", 96'(rv2), 96'd0);
    chk("hold_data", 96'(rd2), 96'h000405_000005);
    for (int i = 0; i < 12; i++) begin
      read_addr = 10'((i * 173) % 1024);
      read_en = i[0];
      tick();
    end
    do_read(10'd1023);
    chk("read1023_2sec", 96'(rd2), 96'h0007FF_0003FF);
    read_en = 1'b0;

    // Deferred swap: pending until frame_done, front unchanged meanwhile
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("wait_pending", 96'(sp2), 96'd1);
    repeat (100) tick();
    chk("wait_front_held", 96'(fs2), 96'd1);
    chk("wait_pending_held", 96'(sp2), 96'd1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("wait_swap_front", 96'(fs2), 96'd0);
    chk("wait_swap_ack", 96'(sa2), 96'd1);
    chk("wait_swap_pending", 96'(sp2), 96'd0);
    tick();
    chk("wait_ack_drop", 96'(sa2), 96'd0);

    // Clear buffer 1 with writes hammering it, then show it
    run_clear("clear_busy_len", 1'b0, 1'b1);
    do_swap_now();
    chk("clear_front", 96'(fs2), 96'd1);
    do_read(10'd0);
    chk("clear_read0", 96'(rd2), 96'd0);
    do_read(10'd777);
    chk("clear_read777", rd4, 96'd0);

    // Back write to address 0 while reading front address 0
    write_en = 1'b1; write_addr = 11'd0; write_data = 24'h123456;
    read_en = 1'b1; read_addr = 10'd0;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    chk("rw_isolation", 96'(rd2), 96'd0);

    // Clear and swap requested together; frame_done mid-clear must not swap
    run_clear("clear_swap_busy_len", 1'b1, 1'b0);
    chk("clear_swap_front_held", 96'(fs2), 96'd1);
    chk("clear_swap_pending", 96'(sp2), 96'd1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("clear_swap_front", 96'(fs2), 96'd0);
    chk("clear_swap_ack", 96'(sa2), 96'd1);
    do_read(10'd7);
    chk("clear_swap_read7", rd4, 96'd0);

    // Reset in clear cycle 100, then a full clear must cover address 0 again
    do_swap_now();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (99) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 96'(bz2), 96'd0);
    chk("abort_front", 96'(fs2), 96'd0);
    chk("abort_pending", 96'(sp4), 96'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      write_en = 1'b1;
      write_addr = (i == 0) ? 11'd0 : (i == 1) ? 11'd1024 : 11'd2047;
      write_data = 24'h5A5A5A;
      tick();
    end
    write_en = 1'b0;
    run_clear("restart_busy_len", 1'b0, 1'b0);
    do_swap_now();
    do_read(10'd0);
    chk("restart_read0", 96'(rd2), 96'd0);
    do_read(10'd1023);
    chk("restart_read1023", 96'(rd2), 96'd0);
    repeat (4) tick();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_dbuf_ram.md
FRAME_DBUF_RAM -- requirements
Module: frame_dbuf_ram

Interface
REQ-001 SHALL provide parameter BITS_PER_PIXEL, default 24, pixel word width.
REQ-002 SHALL provide parameter PANEL_WIDTH, default 64, pixels per row (power of two).
REQ-003 SHALL provide parameter PANEL_HEIGHT, default 32, rows per frame (power of two).
REQ-004 SHALL provide parameter SCAN_SECTIONS, default 2, rows read in parallel (power of two, at most PANEL_HEIGHT).
REQ-005 SHALL provide parameter CLEAR_VALUE, default 0, fill word for clear.
REQ-006 SHALL derive FRAME_WORDS=PANEL_WIDTH*PANEL_HEIGHT, SECTION_WORDS=FRAME_WORDS/SCAN_SECTIONS, WA=clog2(FRAME_WORDS), RA=clog2(SECTION_WORDS).
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 write_addr  in  WA  frame pixel address, row-major.
REQ-010 write_data  in  BITS_PER_PIXEL  pixel to store.
REQ-011 write_en  in  1  write strobe.
REQ-012 read_addr  in  RA  offset within each section.
REQ-013 read_en  in  1  read strobe.
REQ-014 read_data  out  SCAN_SECTIONS*BITS_PER_PIXEL  section s in bits [s*BITS_PER_PIXEL +: BITS_PER_PIXEL]; section 0 = top.
REQ-015 read_valid  out  1  read_data updated this cycle.
REQ-016 frame_done  in  1  one-cycle pulse from scan driver at end of frame.
REQ-017 swap_req  in  1  request buffer exchange.
REQ-018 swap_pending  out  1  swap requested, not yet performed.
REQ-019 swap_ack  out  1  one-cycle pulse when swap performed.
REQ-020 clear_req  in  1  request back-buffer fill with CLEAR_VALUE.
REQ-021 busy  out  1  clear in progress.
REQ-022 front_sel  out  1  index of displayed (front) buffer.

Function
REQ-023 SHALL hold two frame buffers of FRAME_WORDS words, banked by section so all SCAN_SECTIONS words read in one cycle.
REQ-024 Writes SHALL target the back buffer (index ~front_sel) only; section = write_addr / SECTION_WORDS, offset = write_addr mod SECTION_WORDS.
REQ-025 write_en SHALL be ignored while busy=1.
REQ-026 Reads SHALL target the front buffer; read_en at edge N SHALL present data for read_addr at edge N on read_data with read_valid=1 after edge N (latency 1).
REQ-027 read_data SHALL hold its last value while read_en=0; read_valid SHALL be 0 that cycle.
REQ-028 Reads SHALL be unaffected by concurrent writes or clears (different buffers).
REQ-029 Control FSM states SHALL be IDLE, CLEAR, SWAP_WAIT.
REQ-030 IDLE + swap_req + frame_done same cycle: SHALL toggle front_sel at that edge, pulse swap_ack next cycle, stay IDLE.
REQ-031 IDLE + swap_req without frame_done: SHALL enter SWAP_WAIT, swap_pending=1.
REQ-032 SWAP_WAIT + frame_done: SHALL toggle front_sel, pulse swap_ack, clear swap_pending, enter IDLE; swap_req in SWAP_WAIT ignored.
REQ-033 IDLE + clear_req: SHALL enter CLEAR, busy=1, write CLEAR_VALUE to back addresses 0..FRAME_WORDS-1 one per cycle, exactly FRAME_WORDS cycles, then busy=0.
REQ-034 clear_req and swap_req together in IDLE: SHALL clear first, latch swap (swap_pending=1).
REQ-035 swap_req during CLEAR SHALL be latched; on clear completion FSM SHALL enter SWAP_WAIT (frame_done during CLEAR does not swap).
REQ-036 clear_req SHALL be ignored outside IDLE.
REQ-037 front_sel SHALL change only at frame_done, never mid-frame.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, front_sel=0, swap_pending=0, swap_ack=0, busy=0, read_valid=0, read_data=0, clear counter=0.
REQ-039 Reset mid-CLEAR or mid-SWAP_WAIT SHALL abort the operation; memory contents are not reset.

Verification
REQ-040 Defaults: write 2048 words (data=address) to back, swap_req+frame_done -> swap_ack pulse, front_sel=1; read_addr 5 -> read_data top=0x000005, bottom=0x000405 one cycle later.
REQ-041 swap_req alone -> swap_pending=1, front_sel unchanged for 100 cycles; frame_done -> front_sel toggles, swap_ack one cycle, swap_pending=0.
REQ-042 clear_req -> busy=1 exactly 2048 cycles; write_en during busy has no effect; after swap all reads return 0.
REQ-043 Write to back address 0 while reading front address 0 -> read_data reflects front contents, not new write.
REQ-044 SCAN_SECTIONS=4, PANEL_HEIGHT=32 -> read_data 96 bits, section s returns word s*512+read_addr.
REQ-045 rst_n low during CLEAR cycle 100 -> busy=0, front_sel=0 immediately; subsequent clear_req restarts from address 0.
